// File: rtl/fpu_pkg.sv
// Shared constants for the single-precision float conversion datapath.
package fpu_pkg;

   // Conversion sequencer states, 3-bit encoding.
   typedef enum logic [2:0] {
      GET_A   = 3'd0,
      UNPACK  = 3'd1,
      SPECIAL = 3'd2,
      SHIFT   = 3'd3,
      PUT_Z   = 3'd4
   } state_e;

   localparam logic [7:0]  ExpBias   = 8'd127;
   localparam logic [7:0]  ExpInfNan = 8'd255;
   // Smallest biased exponent whose value no longer fits in 32 unsigned bits.
   localparam logic [7:0]  ExpSat    = 8'd159;
   localparam logic [31:0] SatValue  = 32'hFFFF_FFFF;
   // Exponent counter value at which work holds the integer result.
   localparam logic [4:0]  ELast     = 5'd31;

endpackage

// File: rtl/fp32_classify.sv
// Combinational classification of an unpacked single-precision operand.
module fp32_classify
   import fpu_pkg::*;
(
   input  logic        sign,
   input  logic [7:0]  exponent,
   input  logic [22:0] mantissa,
   output logic        is_nan,
   output logic        is_neg,
   output logic        is_small,
   output logic        is_sat
);

   // Flags are independent; the caller applies the priority order.
   always_comb begin
      is_nan   = (exponent == ExpInfNan) && (mantissa != 23'd0);
      is_neg   = sign;
      is_small = (exponent < ExpBias);
      is_sat   = (exponent >= ExpSat);
   end

endmodule

// File: rtl/float_to_unsint.sv
// Multi-cycle float32 to unsigned 32-bit integer converter, truncating toward zero.
module float_to_unsint
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] input_a,
   output logic [31:0] output_z,
   output logic        complete
);

   state_e      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic        sign_q, sign_d;
   logic [7:0]  exp_q, exp_d;
   logic [22:0] man_q, man_d;
   logic [31:0] work_q, work_d;
   logic [4:0]  e_q, e_d;
   logic [31:0] result_q, result_d;
   logic [31:0] z_q, z_d;
   logic        complete_q, complete_d;

   logic is_nan, is_neg, is_small, is_sat;

   fp32_classify u_classify (
      .sign     (sign_q),
      .exponent (exp_q),
      .mantissa (man_q),
      .is_nan   (is_nan),
      .is_neg   (is_neg),
      .is_small (is_small),
      .is_sat   (is_sat)
   );

   // Next-state and datapath updates for each conversion step.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      sign_d     = sign_q;
      exp_d      = exp_q;
      man_d      = man_q;
      work_d     = work_q;
      e_d        = e_q;
      result_d   = result_q;
      z_d        = z_q;
      complete_d = complete_q;

      unique case (state_q)
         GET_A: begin
            a_d        = input_a;
            complete_d = 1'b0;
            state_d    = UNPACK;
         end
         UNPACK: begin
            sign_d  = a_q[31];
            exp_d   = a_q[30:23];
            man_d   = a_q[22:0];
            state_d = SPECIAL;
         end
         SPECIAL: begin
            state_d = PUT_Z;
            if (is_nan) begin
               result_d = 32'd0;
            end else if (is_neg) begin
               result_d = 32'd0;
            end else if (is_small) begin
               result_d = 32'd0;
            end else if (is_sat) begin
               result_d = SatValue;
            end else begin
               // Hidden one at bit 31: value is work * 2^(e-31).
               work_d  = {1'b1, man_q, 8'h00};
               e_d     = 5'(exp_q - ExpBias);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (e_q != ELast) begin
               work_d = work_q >> 1;
               e_d    = e_q + 5'd1;
            end else begin
               result_d = work_q;
               state_d  = PUT_Z;
            end
         end
         PUT_Z: begin
            z_d        = result_q;
            complete_d = 1'b1;
            state_d    = GET_A;
         end
         default: state_d = GET_A;
      endcase
   end

   // Control and output registers; en low clears outputs but holds the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= GET_A;
         z_q        <= 32'd0;
         complete_q <= 1'b0;
      end else if (!en) begin
         z_q        <= 32'd0;
         complete_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         z_q        <= z_d;
         complete_q <= complete_d;
      end
   end

   // Datapath registers are never observed before a full pass, so no reset.
   always_ff @(posedge clk) begin
      if (!rst && en) begin
         a_q      <= a_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         man_q    <= man_d;
         work_q   <= work_d;
         e_q      <= e_d;
         result_q <= result_d;
      end
   end

   assign output_z = z_q;
   assign complete = complete_q;

endmodule

// File: tb/tb_float_to_unsint.sv
// Self-checking bench for float_to_unsint: directed table, corner sequences, random vs model.
module tb_float_to_unsint;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] input_a;
   logic [31:0] output_z;
   logic        complete;

   int tests  = 0;
   int failed = 0;

   localparam int MaxEdges = 50;

   float_to_unsint dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .input_a  (input_a),
      .output_z (output_z),
      .complete (complete)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] z;
      int          edge_n;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   // Reference: value = (1.M * 2^23) * 2^(E-150), truncated; special cases first.
   function automatic void model(input logic [31:0] a, output logic [31:0] z,
                                 output int edge_n);
      int unsigned ex;
      logic [31:0] m24;
      ex  = a[30:23];
      m24 = {8'd0, 1'b1, a[22:0]};
      edge_n = 3;
      if (ex == 255 && a[22:0] != 0)  z = 32'd0;
      else if (a[31])                 z = 32'd0;
      else if (ex < 127)              z = 32'd0;
      else if (ex >= 159)             z = 32'hFFFF_FFFF;
      else begin
         if (ex >= 150) z = m24 << (ex - 150);
         else           z = m24 >> (150 - ex);
         edge_n = 162 - ex;
      end
   endfunction

   // Assumes the DUT is in GET_A at the next edge; returns at #1 after the PUT_Z edge.
   task automatic run_conv(input string name, input logic [31:0] a, output logic [31:0] z,
                           output int edges);
      input_a = a;
      @(posedge clk); #1;
      check({name, "_complete_cleared"}, {31'd0, complete}, 32'd0);
      input_a = $urandom;  // must be ignored mid-conversion
      edges = 0;
      while (!complete && edges < MaxEdges) begin
         @(posedge clk); #1;
         edges++;
      end
      if (!complete) begin
         failed++;
         tests++;
         $display("FAIL %s_timeout: got no complete expected complete within %0d edges",
                  name, MaxEdges);
      end
      z = output_z;
   endtask

   initial begin
      logic [31:0] z, exp_z, r;
      logic [7:0]  ex;
      int          edges, exp_e;

      vecs.push_back('{"one",      32'h3F80_0000, 32'd1,          35});
      vecs.push_back('{"pi",       32'h4049_0FDB, 32'd3,          34});
      vecs.push_back('{"max_fit",  32'h4F7F_FFFF, 32'hFFFF_FF00,  4});
      vecs.push_back('{"below1",   32'h3F7F_FFFF, 32'd0,          3});
      vecs.push_back('{"two32",    32'h4F80_0000, 32'hFFFF_FFFF,  3});
      vecs.push_back('{"pinf",     32'h7F80_0000, 32'hFFFF_FFFF,  3});
      vecs.push_back('{"neg_one",  32'hBF80_0000, 32'd0,          3});
      vecs.push_back('{"qnan",     32'h7FC0_0000, 32'd0,          3});
      vecs.push_back('{"neg_zero", 32'h8000_0000, 32'd0,          3});
      vecs.push_back('{"ninf",     32'hFF80_0000, 32'd0,          3});
      vecs.push_back('{"snan",     32'h7F80_0001, 32'd0,          3});
      vecs.push_back('{"denorm",   32'h0000_0001, 32'd0,          3});
      vecs.push_back('{"ten",      32'h4120_0000, 32'd10,         32});
      // Back-to-back pair: 100 then 1000, no idle cycle between.
      vecs.push_back('{"hundred",  32'h42C8_0000, 32'd100,        29});
      vecs.push_back('{"thousand", 32'h447A_0000, 32'd1000,       26});

      rst = 1'b1;
      en = 1'b1;
      input_a = 32'h3F80_0000;
      repeat (3) @(posedge clk);
      #1;
      check("reset_output_z", output_z, 32'd0);
      check("reset_complete", {31'd0, complete}, 32'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_conv(vecs[i].name, vecs[i].a, z, edges);
         check({vecs[i].name, "_z"}, z, vecs[i].z);
         check({vecs[i].name, "_edge"}, edges, vecs[i].edge_n);
      end

      // Reset mid-SHIFT of 1.0.
      input_a = 32'h3F80_0000;
      @(posedge clk); #1;
      repeat (10) @(posedge clk);
      #1;
      check("hold_between_results", output_z, 32'd1000);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_output_z", output_z, 32'd0);
      check("midrst_complete", {31'd0, complete}, 32'd0);
      rst = 1'b0;
      run_conv("after_rst", 32'h4120_0000, z, edges);
      check("after_rst_z", z, 32'd10);
      check("after_rst_edge", edges, 32'd32);

      // Five-cycle stall mid-SHIFT of 1.0.
      input_a = 32'h3F80_0000;
      @(posedge clk); #1;
      input_a = 32'h4F80_0000;
      repeat (10) @(posedge clk);
      #1;
      check("prestall_complete", {31'd0, complete}, 32'd0);
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("stall_output_z", output_z, 32'd0);
         check("stall_complete", {31'd0, complete}, 32'd0);
      end
      en = 1'b1;
      edges = 15;
      while (!complete && edges < 60) begin
         @(posedge clk); #1;
         edges++;
      end
      check("stall_edge", edges, 32'd40);
      check("stall_z", output_z, 32'd1);

      // Random operands, half biased into the normal in-range window.
      for (int i = 0; i < 150; i++) begin
         r = $urandom;
         if (i % 2 == 1) begin
            ex = 8'(127 + $urandom_range(0, 31));
            r  = {1'b0, ex, r[22:0]};
         end
         model(r, exp_z, exp_e);
         run_conv("rand", r, z, edges);
         if (z !== exp_z) $display("  operand %h", r);
         check("rand_z", z, exp_z);
         check("rand_edge", edges, exp_e);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish before time limit");
      $fatal(1, "timeout");
   end

endmodule
